// File: rtl/drawing_pkg.sv
// rtl/drawing_pkg.sv - shared state/mode codes and byte-lane helpers for the drawing engine
package drawing_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        MODE_LINE = 1'b0,
        MODE_RECT = 1'b1
    } mode_t;

    function automatic bit bpp_legal(input int unsigned bpp);
        return (bpp == 8) || (bpp == 16);
    endfunction

    // Active-low byte enables for one pixel inside a 32-bit word.
    function automatic logic [3:0] nbyte_decode(input logic [1:0] lsb, input int unsigned bpp);
        logic [3:0] nb;
        if (bpp == 16) begin
            nb = lsb[1] ? 4'b0011 : 4'b1100;
        end else begin
            nb = ~(4'b0001 << lsb);
        end
        return nb;
    endfunction

endpackage

// File: rtl/drawing_byte_lane.sv
// rtl/drawing_byte_lane.sv - pixel address LSBs and colour to write-port byte enables and data
module drawing_byte_lane
    import drawing_pkg::*;
#(
    parameter int unsigned BPP = 8
) (
    input  logic [1:0]     lsb,
    input  logic [BPP-1:0] colour,
    output logic [3:0]     nbyte,
    output logic [31:0]    data
);

    assign nbyte = nbyte_decode(lsb, BPP);
    assign data  = {(32 / BPP){colour}};

endmodule

// File: rtl/drawing_engine.sv
// rtl/drawing_engine.sv - Bresenham line / solid rectangle plotter; DRAW_CLIP_EN adds address-window clipping
module drawing_engine
    import drawing_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned LEN_W  = 10,
    parameter int unsigned STEP_W = 11,
    parameter int unsigned BPP    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    input  logic [15:0]       r6,
    input  logic [15:0]       r7,
    input  logic [ADDR_W-1:0] clip_lo,
    input  logic [ADDR_W-1:0] clip_hi,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-3:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic [31:0]       de_data
);

    if (!bpp_legal(BPP)) begin : g_bad_bpp
        $error("drawing_engine: BPP must be 8 or 16");
    end

    localparam logic [ADDR_W-1:0] PIX_BYTES = ADDR_W'(BPP / 8);

    state_t                   state, state_nx;
    mode_t                    mode;
    logic [LEN_W-1:0]         len_a, len_b, col, row;
    logic [ADDR_W-1:0]        step_a, step_d, addr, row_base;
    logic [BPP-1:0]           colour;
    logic signed [LEN_W+1:0]  err, cmp, two_b, two_diff;
    logic [31:0]              addr_word;
    logic [ADDR_W-1:0]        line_step_a, line_step_d, stride;
    logic                     start, last, visible, adv;
    logic                     unused_ops;

    assign addr_word   = {r5, r4};
    assign line_step_a = {{(ADDR_W - STEP_W){r2[STEP_W-1]}}, r2[STEP_W-1:0]};
    assign line_step_d = {{(ADDR_W - STEP_W){r3[STEP_W-1]}}, r3[STEP_W-1:0]};
    assign stride      = {{(ADDR_W - 16){r2[15]}}, r2};
    assign unused_ops  = ^{r0, r1, r2, r3, r6, r7, addr_word, clip_lo, clip_hi};

    assign start    = (state == IDLE) && req;
    assign busy     = (state == BUSY);
    assign two_b    = {1'b0, len_b, 1'b0};
    assign two_diff = ({2'b00, len_a} - {2'b00, len_b}) << 1;
    assign cmp      = err - two_b;
    assign last     = (mode == MODE_LINE) ? (col == len_a) : ((col == len_a) && (row == len_b));

`ifdef DRAW_CLIP_EN
    assign visible = (addr >= clip_lo) && (addr <= clip_hi);
`else
    assign visible = 1'b1;
`endif

    // Hidden pixels are skipped at one per clock as though the controller accepted them.
    assign adv    = busy && (de_ack || !visible);
    assign de_req = busy && visible && !(last && de_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            state <= state_nx;
            ack   <= start;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = BUSY;
            BUSY:    if (adv && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= MODE_LINE;
            len_a    <= '0;
            len_b    <= '0;
            col      <= '0;
            row      <= '0;
            step_a   <= '0;
            step_d   <= '0;
            addr     <= '0;
            row_base <= '0;
            colour   <= '0;
            err      <= '0;
        end else if (start) begin
            mode     <= mode_t'(r7[0]);
            len_a    <= r0[LEN_W-1:0];
            len_b    <= r1[LEN_W-1:0];
            step_a   <= r7[0] ? stride : line_step_a;
            step_d   <= line_step_d;
            colour   <= r6[BPP-1:0];
            addr     <= addr_word[ADDR_W-1:0];
            row_base <= addr_word[ADDR_W-1:0];
            err      <= $signed({2'b00, r0[LEN_W-1:0]});
            col      <= '0;
            row      <= '0;
        end else if (adv && !last) begin
            if (mode == MODE_LINE) begin
                // col counts plotted pixels; the line ends when it reaches the major length.
                col <= col + LEN_W'(1);
                if (!cmp[LEN_W+1]) begin
                    err  <= cmp;
                    addr <= addr + step_a;
                end else begin
                    err  <= err + two_diff;
                    addr <= addr + step_d;
                end
            end else if (col != len_a) begin
                col  <= col + LEN_W'(1);
                addr <= addr + PIX_BYTES;
            end else begin
                col      <= '0;
                row      <= row + LEN_W'(1);
                row_base <= row_base + step_a;
                addr     <= row_base + step_a;
            end
        end
    end

    assign de_addr = addr[ADDR_W-1:2];

    drawing_byte_lane #(
        .BPP (BPP)
    ) u_byte_lane (
        .lsb    (addr[1:0]),
        .colour (colour),
        .nbyte  (de_nbyte),
        .data   (de_data)
    );

endmodule

// File: tb/tb_drawing_engine.sv
// tb/tb_drawing_engine.sv - self-checking bench: pixel-list reference model plus directed and random commands
module tb_drawing_engine;

    localparam int AW    = 20;
    localparam int AMASK = 32'h000F_FFFF;

    logic          clk = 1'b0;
    logic          rst_n, req, ack, busy, de_req, de_ack;
    logic [15:0]   r0, r1, r2, r3, r4, r5, r6, r7;
    logic [AW-1:0] clip_lo, clip_hi;
    logic [AW-3:0] de_addr;
    logic [3:0]    de_nbyte;
    logic [31:0]   de_data;

    logic          req16, ack16, busy16, de_req16, de_ack16;
    logic [AW-3:0] de_addr16;
    logic [3:0]    de_nbyte16;
    logic [31:0]   de_data16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          vis;
    } pix_t;

    pix_t       exp_q[$];
    pix_t       mon_p;
    bit         exp_active, exp_ack, stall, ack_all;
    logic [7:0] exp_col;
    int         checks, failures;

    int t1_addr [5] = '{32'h100, 32'h101, 32'h242, 32'h243, 32'h384};
    int t1_waddr[5] = '{32'h40, 32'h40, 32'h90, 32'h90, 32'hE1};
    int t1_nb   [5] = '{32'hE, 32'hD, 32'hB, 32'h7, 32'hE};
    int t2_addr [6] = '{32'h1000, 32'h1001, 32'h1002, 32'h1140, 32'h1141, 32'h1142};

    drawing_engine #(.ADDR_W(20), .LEN_W(10), .STEP_W(11), .BPP(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .clip_lo(clip_lo), .clip_hi(clip_hi),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte), .de_data(de_data)
    );

    drawing_engine #(.ADDR_W(20), .LEN_W(10), .STEP_W(11), .BPP(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16), .ack(ack16), .busy(busy16),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .clip_lo(clip_lo), .clip_hi(clip_hi),
        .de_req(de_req16), .de_ack(de_ack16), .de_addr(de_addr16), .de_nbyte(de_nbyte16), .de_data(de_data16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int sext(input int v, input int w);
        int r;
        r = v & ((1 << w) - 1);
        if (r >= (1 << (w - 1))) r = r - (1 << w);
        return r;
    endfunction

    function automatic logic [3:0] exp_nbyte(input logic [1:0] lsb);
        logic [3:0] one;
        one = 4'b0001;
        return 4'hF ^ (one << lsb);
    endfunction

    task automatic push_pix(input int a);
        pix_t p;
        p.a   = a[AW-1:0];
        p.vis = 1'b1;
`ifdef DRAW_CLIP_EN
        p.vis = (p.a >= clip_lo) && (p.a <= clip_hi);
`endif
        exp_q.push_back(p);
    endtask

    // Expected pixel list straight from the plotting rules: Bresenham walk or row/column raster.
    task automatic build_model(input logic [15:0] o0, o1, o2, o3, o4, o5, o7);
        int la, lb, a, e, c;
        la = int'(o0[9:0]);
        lb = int'(o1[9:0]);
        a  = int'({o5, o4}) & AMASK;
        if (o7[0] == 1'b0) begin
            e = la;
            for (int i = 0; i <= la; i++) begin
                push_pix(a);
                c = e - 2 * lb;
                if (c >= 0) begin
                    e = c;
                    a = (a + sext(int'(o2), 11)) & AMASK;
                end else begin
                    e = e + 2 * (la - lb);
                    a = (a + sext(int'(o3), 11)) & AMASK;
                end
            end
        end else begin
            for (int y = 0; y <= lb; y++)
                for (int x = 0; x <= la; x++)
                    push_pix((a + y * sext(int'(o2), 16) + x) & AMASK);
        end
    endtask

    always @(posedge clk) begin
        #1;
        de_ack = stall ? 1'b0 : (ack_all ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    always @(negedge clk) begin
        check("ack", 32'(ack), 32'(exp_ack));
        exp_ack = 1'b0;
        if (exp_active && exp_q.size() > 0) begin
            mon_p = exp_q[0];
            check("busy", 32'(busy), 32'd1);
            check("de_req", 32'(de_req), 32'(mon_p.vis && !(exp_q.size() == 1 && de_ack)));
            check("de_addr", 32'(de_addr), 32'(mon_p.a[AW-1:2]));
            check("de_nbyte", 32'(de_nbyte), 32'(exp_nbyte(mon_p.a[1:0])));
            check("de_data", de_data, {4{exp_col}});
            if (de_ack || !mon_p.vis) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_active = 1'b0;
            end
        end else begin
            check("busy_idle", 32'(busy), 32'd0);
            check("de_req_idle", 32'(de_req), 32'd0);
        end
    end

    task automatic start_cmd(input logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7);
        @(posedge clk);
        #1;
        r0 = o0; r1 = o1; r2 = o2; r3 = o3; r4 = o4; r5 = o5; r6 = o6; r7 = o7;
        req = 1'b1;
        exp_q.delete();
        exp_col = o6[7:0];
        build_model(o0, o1, o2, o3, o4, o5, o7);
        @(posedge clk);
        #1;
        req        = 1'b0;
        exp_active = 1'b1;
        exp_ack    = 1'b1;
    endtask

    task automatic finish_cmd(input string name);
        for (int c = 0; c < 2000 && exp_active; c++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_done"}, 32'(exp_active), 32'd0);
        exp_active = 1'b0;
        exp_q.delete();
        check({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7;
        int len, mn, nvis;
        rst_n = 1'b0; req = 1'b0; req16 = 1'b0; de_ack16 = 1'b0;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0; r6 = '0; r7 = '0;
        clip_lo = '0; clip_hi = '1;
        stall = 1'b0; ack_all = 1'b1; exp_active = 1'b0; exp_ack = 1'b0; exp_col = '0;
        checks = 0; failures = 0;

        #7;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_de_req", 32'(de_req), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Line with always-ready controller; model pinned to hand-computed values.
        start_cmd(16'd4, 16'd2, 16'd1, 16'h141, 16'h100, 16'h0, 16'h5A, 16'h0);
        check("pin_t1_len", 32'(exp_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < exp_q.size(); i++) begin
            check("pin_t1_addr", 32'(exp_q[i].a), t1_addr[i]);
            check("pin_t1_waddr", 32'(exp_q[i].a[AW-1:2]), t1_waddr[i]);
            check("pin_t1_nbyte", 32'(exp_nbyte(exp_q[i].a[1:0])), t1_nb[i]);
        end
        finish_cmd("t1");

        start_cmd(16'd2, 16'd1, 16'h140, 16'h0, 16'h1000, 16'h0, 16'hC3, 16'h1);
        check("pin_t2_len", 32'(exp_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < exp_q.size(); i++)
            check("pin_t2_addr", 32'(exp_q[i].a), t2_addr[i]);
        finish_cmd("t2");

        // Controller stalls three cycles mid-line.
        start_cmd(16'd10, 16'd3, 16'd1, 16'h140, 16'h2000, 16'h0, 16'h11, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) stall = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) stall = 1'b0;
        finish_cmd("t3");

        // Reset during pixel 3, then a clean restart.
        start_cmd(16'd4, 16'd2, 16'd1, 16'h141, 16'h100, 16'h0, 16'h5A, 16'h0);
        for (int c = 0; c < 50 && exp_q.size() > 3; c++) begin
            @(posedge clk);
            #1;
        end
        check("t4_at_pix3", 32'(exp_q.size()), 32'd3);
        #2;
        rst_n = 1'b0;
        exp_active = 1'b0;
        exp_ack = 1'b0;
        exp_q.delete();
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_de_req", 32'(de_req), 32'd0);
        check("t4_ack", 32'(ack), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_cmd(16'd4, 16'd2, 16'd1, 16'h141, 16'h100, 16'h0, 16'h5A, 16'h0);
        finish_cmd("t4_restart");

        // 16-bit pixel depth, single-pixel rectangle.
        @(posedge clk);
        #1;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = 16'h0002; r5 = '0; r6 = 16'hBEEF; r7 = 16'h0001;
        req16 = 1'b1;
        @(posedge clk);
        #1;
        req16 = 1'b0;
        check("t5_ack", 32'(ack16), 32'd1);
        check("t5_busy", 32'(busy16), 32'd1);
        check("t5_de_req", 32'(de_req16), 32'd1);
        check("t5_nbyte", 32'(de_nbyte16), 32'b0011);
        check("t5_data", de_data16, 32'hBEEFBEEF);
        check("t5_addr", 32'(de_addr16), 32'd0);
        de_ack16 = 1'b1;
        #1;
        check("t5_de_req_fall", 32'(de_req16), 32'd0);
        @(posedge clk);
        #1;
        de_ack16 = 1'b0;
        check("t5_busy_end", 32'(busy16), 32'd0);
        check("t5_ack_end", 32'(ack16), 32'd0);

`ifdef DRAW_CLIP_EN
        clip_lo = 20'h01001;
        clip_hi = 20'h01141;
        start_cmd(16'd2, 16'd1, 16'h140, 16'h0, 16'h1000, 16'h0, 16'h77, 16'h1);
        nvis = 0;
        foreach (exp_q[i]) if (exp_q[i].vis) nvis++;
        check("pin_t6_visible", 32'(nvis), 32'd4);
        finish_cmd("t6");
        clip_lo = '0;
        clip_hi = '1;
`endif

        // Random commands with a randomly stalling controller.
        ack_all = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                len = $urandom_range(0, 20);
                mn  = $urandom_range(0, len);
                o0 = {6'($urandom), 10'(len)};
                o1 = {6'($urandom), 10'(mn)};
                o7 = {15'($urandom), 1'b0};
            end else begin
                o0 = 16'($urandom_range(0, 5));
                o1 = 16'($urandom_range(0, 4));
                o7 = {15'($urandom), 1'b1};
            end
            o2 = 16'($urandom);
            o3 = 16'($urandom);
            o4 = 16'($urandom);
            o5 = 16'($urandom);
            o6 = 16'($urandom);
            start_cmd(o0, o1, o2, o3, o4, o5, o6, o7);
            finish_cmd("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
